// File: rtl/burst_ram_responder_pkg.sv
// Shared types and bus encodings for the burst RAM responder.
package burst_ram_responder_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_WAIT  = 2'd1,
        RSP_READ  = 2'd2,
        RSP_WRITE = 2'd3
    } rsp_state_e;

    // Registered response bundle driven back onto the memory bus.
    typedef struct packed {
        logic              read_valid;
        logic              req_data;
        logic              last;
        logic [DATA_W-1:0] data;
    } rsp_out_t;

endpackage

// File: rtl/burst_ram_responder_ram_word_array.sv
// Single-port word array: asynchronous read, synchronous write, zero power-up image.
module ram_word_array
    import burst_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [DATA_W-1:0] word_array_t [DEPTH];

    // Power-up image: all words zero.
    function automatic word_array_t load_image();
        word_array_t img;
        img = '{default: '0};
        return img;
    endfunction

    word_array_t mem = load_image();

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/burst_ram_responder.sv
// RAM-side memory-bus responder serving cache-line bursts and single-word transfers.
module burst_ram_responder
    import burst_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter string       INIT_FILE    = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic              mem_enable,
    input  logic              mem_rw,
    input  logic              mem_op_size,
    input  logic              mem_finishes_op,
    input  logic [DATA_W-1:0] mem_write,
    output logic              mem_req_data,
    output logic [DATA_W-1:0] mem_read,
    output logic              mem_read_valid,
    output logic              mem_last
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    rsp_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   word_q, word_d;
    logic                    single_q, single_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    rsp_out_t                out_q, out_d;

    logic [BEAT_W-1:0]       last_idx_c;
    logic [ADDR_WIDTH-1:0]   ram_addr_c;
    logic                    ram_we_c;
    logic [DATA_W-1:0]       ram_rdata_c;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    assign last_idx_c = single_q ? '0 : BEAT_W'(BURST_LEN - 1);
    assign ram_addr_c = word_q + ADDR_WIDTH'(beat_q);

    ram_word_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c),
        .addr    (ram_addr_c),
        .wdata   (mem_write),
        .rdata_c (ram_rdata_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RSP_IDLE;
            word_q   <= '0;
            single_q <= 1'b0;
            beat_q   <= '0;
            lat_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            single_q <= single_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            out_q    <= out_d;
        end
    end

    // Next state, beat bookkeeping and the output bundle for the following cycle.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        single_d = single_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        out_d    = '0;
        ram_we_c = 1'b0;

        case (state_q)
            RSP_IDLE: begin
                if (mem_enable) begin
                    word_d   = mem_addr[ADDR_WIDTH+1:2];
                    single_d = mem_op_size;
                    beat_d   = '0;
                    if (mem_rw == MEM_WRITE) begin
                        state_d       = RSP_WRITE;
                        out_d.req_data = 1'b1;
                        out_d.last    = mem_op_size;
                    end else begin
                        state_d = RSP_WAIT;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                    end
                end
            end

            RSP_WAIT: begin
                if (!mem_enable) begin
                    state_d = RSP_IDLE;
                end else if (lat_q == '0) begin
                    state_d          = RSP_READ;
                    out_d.read_valid = 1'b1;
                    out_d.data       = ram_rdata_c;
                    out_d.last       = (beat_q == last_idx_c);
                    beat_d           = beat_q + BEAT_W'(1);
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            RSP_READ: begin
                if (!mem_enable || out_q.last) begin
                    state_d = RSP_IDLE;
                end else begin
                    out_d.read_valid = 1'b1;
                    out_d.data       = ram_rdata_c;
                    out_d.last       = (beat_q == last_idx_c);
                    beat_d           = beat_q + BEAT_W'(1);
                end
            end

            RSP_WRITE: begin
                if (!mem_enable) begin
                    state_d = RSP_IDLE;
                end else begin
                    ram_we_c = 1'b1;
                    beat_d   = beat_q + BEAT_W'(1);
                    if (out_q.last) begin
                        state_d = RSP_IDLE;
                    end else begin
                        // finishes_op on this beat makes the next beat the last one
                        out_d.req_data = 1'b1;
                        out_d.last     = (mem_finishes_op && !single_q) || (beat_d == last_idx_c);
                    end
                end
            end

            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    assign mem_req_data   = out_q.req_data;
    assign mem_read       = out_q.data;
    assign mem_read_valid = out_q.read_valid;
    assign mem_last       = out_q.last;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed self-checking bench for burst_ram_responder with a reference word array.
module tb_burst_ram_responder;

    localparam int unsigned ADDR_WIDTH   = 12;
    localparam int unsigned BURST_LEN    = 8;
    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned DEPTH        = 2 ** ADDR_WIDTH;
    localparam logic        RD           = 1'b0;
    localparam logic        WR           = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_enable = 1'b0;
    logic        mem_rw = 1'b0;
    logic        mem_op_size = 1'b0;
    logic        mem_finishes_op = 1'b0;
    logic [31:0] mem_write = '0;
    logic        mem_req_data;
    logic [31:0] mem_read;
    logic        mem_read_valid;
    logic        mem_last;

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_mem [DEPTH];

    burst_ram_responder #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BURST_LEN    (BURST_LEN),
        .READ_LATENCY (READ_LATENCY),
        .INIT_FILE    ("")
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_addr        (mem_addr),
        .mem_enable      (mem_enable),
        .mem_rw          (mem_rw),
        .mem_op_size     (mem_op_size),
        .mem_finishes_op (mem_finishes_op),
        .mem_write       (mem_write),
        .mem_req_data    (mem_req_data),
        .mem_read        (mem_read),
        .mem_read_valid  (mem_read_valid),
        .mem_last        (mem_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(mem_read_valid), 32'd0);
        chk({tag, "_req"},   32'(mem_req_data),   32'd0);
        chk({tag, "_last"},  32'(mem_last),       32'd0);
        chk({tag, "_data"},  mem_read,            32'd0);
    endtask

    // Write transaction; stop_beat >= 0 aborts on that beat (enable drop or reset).
    task automatic write_txn(input logic [31:0] addr, input logic single, input int beats,
                             input int fin_beat, input int stop_beat, input logic use_rst,
                             input logic [31:0] seed, input logic [31:0] step);
        logic [11:0] w;
        logic [31:0] d;
        w = addr[13:2];
        mem_addr = addr; mem_rw = WR; mem_op_size = single; mem_enable = 1'b1;
        mem_finishes_op = 1'b0;
        @(negedge clk);
        for (int k = 0; k < beats; k++) begin
            chk("wr_req",  32'(mem_req_data), 32'd1);
            chk("wr_last", 32'(mem_last), 32'(k == beats - 1));
            d = seed + step * 32'(k);
            mem_write = d;
            mem_finishes_op = (k == fin_beat);
            if (k == stop_beat) begin
                mem_finishes_op = 1'b0;
                if (use_rst) begin
                    rst_n = 1'b0;
                    #1;
                    chk_quiet("rst_mid_write");
                    mem_enable = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    mem_enable = 1'b0;
                    @(negedge clk);
                    chk_quiet("wr_abort");
                end
                return;
            end
            ref_mem[w + 12'(k)] = d;
            @(negedge clk);
        end
        mem_enable = 1'b0;
        mem_finishes_op = 1'b0;
        chk_quiet("wr_idle");
    endtask

    // Read transaction; abort_k >= 0 drops enable during that beat.
    task automatic read_txn(input logic [31:0] addr, input logic single, input int beats,
                            input int abort_k);
        logic [11:0] w;
        w = addr[13:2];
        mem_addr = addr; mem_rw = RD; mem_op_size = single; mem_enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            chk("rd_latency", 32'(mem_read_valid), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < beats; k++) begin
            chk("rd_valid", 32'(mem_read_valid), 32'd1);
            chk("rd_data",  mem_read, ref_mem[w + 12'(k)]);
            chk("rd_last",  32'(mem_last), 32'(k == beats - 1));
            if (k == abort_k) begin
                mem_enable = 1'b0;
                @(negedge clk);
                chk_quiet("rd_abort");
                @(negedge clk);
                chk_quiet("rd_abort_hold");
                return;
            end
            @(negedge clk);
        end
        mem_enable = 1'b0;
        chk_quiet("rd_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

        // Reset state
        #1;
        chk_quiet("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset");

        // Preload words 0x10..0x17 with 0xA0..0xA7 via single writes
        for (int k = 0; k < 8; k++)
            write_txn(32'h40 + 32'(4 * k), 1'b1, 1, -1, -1, 1'b0, 32'hA0 + 32'(k), 32'd0);

        // Burst read 0xA0..0xA7
        chk("model_a0", ref_mem[12'h10], 32'hA0);
        read_txn(32'h40, 1'b0, 8, -1);

        // Burst write 0x11..0x88 at word 0x20, then read back
        write_txn(32'h80, 1'b0, 8, -1, -1, 1'b0, 32'h11, 32'h11);
        chk("model_88", ref_mem[12'h27], 32'h88);
        read_txn(32'h80, 1'b0, 8, -1);

        // Single write then single read
        write_txn(32'h1FFC, 1'b1, 1, -1, -1, 1'b0, 32'hDEADBEEF, 32'd0);
        read_txn(32'h1FFC, 1'b1, 1, -1);

        // Wrap at the top of the array, both directions
        write_txn(32'h3FFC, 1'b0, 8, -1, -1, 1'b0, 32'h500, 32'd1);
        read_txn(32'h3FFC, 1'b0, 8, -1);
        chk("model_wrap0", ref_mem[12'h000], 32'h501);
        read_txn(32'h0, 1'b1, 1, -1);

        // Early finish: finishes_op on beat 2, last on beat 3, 4 words written
        write_txn(32'h400, 1'b0, 4, 2, -1, 1'b0, 32'h600, 32'd1);
        chk("model_early4", ref_mem[12'h104], 32'h0);
        read_txn(32'h400, 1'b0, 8, -1);

        // Read abort after 3 beats, then a fresh single read
        read_txn(32'h40, 1'b0, 8, 2);
        read_txn(32'h44, 1'b1, 1, -1);

        // Reset during beat 3 of a burst write: beats 0..2 persist
        write_txn(32'h800, 1'b0, 8, -1, 3, 1'b1, 32'h7000, 32'd1);
        read_txn(32'h800, 1'b0, 8, -1);

        // Write abort on beat 2 via enable drop: beats 0..1 persist
        write_txn(32'hC00, 1'b0, 8, -1, 2, 1'b0, 32'h9000, 32'd1);
        read_txn(32'hC00, 1'b0, 8, -1);

        // Back-to-back: instruction burst read then data burst write, one idle cycle apart
        read_txn(32'h80, 1'b0, 8, -1);
        write_txn(32'h1000, 1'b0, 8, -1, -1, 1'b0, 32'hC0DE0000, 32'h10);
        read_txn(32'h1000, 1'b0, 8, -1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_ram_responder.md
Name: burst_ram_responder

Overview:
- RAM-side responder for the memory bus driven by the memory arbiter: `mem_addr`, `mem_enable`, `mem_rw`, `mem_op_size`, `mem_finishes_op` and `mem_write` come in; `mem_read`, `mem_read_valid`, `mem_req_data` and `mem_last` go out.
- Backs the bus with an on-chip word array.
- Serves cache-line bursts (instruction cache, data cache) and single-word transfers (external devices).
- Used as the Basys3 block-RAM main memory and as the bench model for the arbiter.

Parameters:
- ADDR_WIDTH, 12, word-address bits; depth = 2^ADDR_WIDTH words.
- BURST_LEN, 8, words per burst when `mem_op_size` = 0; power of two, ≥ 2.
- READ_LATENCY, 2, cycles from the accepting edge to the first read beat; must be ≥ 1.
- INIT_FILE, "", hex image loaded at elaboration; empty means the array powers up at 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word, bits [1:0] are ignored.
- mem_enable  in  1  request; held high by the initiator for the whole transaction.
- mem_rw  in  1  `MEM_READ` / `MEM_WRITE` (defines.v).
- mem_op_size  in  1  0 = burst of BURST_LEN words, 1 = single word.
- mem_finishes_op  in  1  write only: the current data beat is the final beat.
- mem_write  in  32  write data; valid in any cycle in which `mem_req_data` = 1.
- mem_req_data  out  1  requests one write-data word this cycle.
- mem_read  out  32  read data.
- mem_read_valid  out  1  `mem_read` holds a valid beat.
- mem_last  out  1  final beat of the transaction.

Behaviour:
- All outputs are registered.
- Reset values: `mem_req_data`, `mem_read_valid` and `mem_last` = 0; `mem_read` = 0; state = IDLE; beat and latency counters = 0. Array contents are not reset.
- Reset asserted mid-transaction: outputs go to reset values immediately. Words already written are kept; the remaining beats are discarded.
- States:
  - IDLE: on an edge with `mem_enable` = 1, latch the word index W = `mem_addr[ADDR_WIDTH+1:2]`, `mem_rw` and `mem_op_size`. Set N = 1 if `mem_op_size` = 1, otherwise BURST_LEN. Clear beat b. Reads go to WAIT with the counter at READ_LATENCY−1; writes go to WRITE.
  - WAIT: count down. When the counter reaches 0 at an edge, go to READ. The first valid beat therefore appears READ_LATENCY cycles after the accepting edge.
  - READ: each cycle `mem_read_valid` = 1 and `mem_read` = array[(W+b) mod depth]. `mem_last` = 1 when b = N−1; that same edge returns to IDLE with outputs cleared.
  - WRITE: starts one cycle after acceptance. `mem_req_data` = 1 each cycle; at each edge, array[(W+b) mod depth] ← `mem_write` and b increments. `mem_last` = 1 on the cycle where b = N−1.
  - Early write termination: `mem_last` is registered, so `mem_finishes_op` sampled high on a beat ends the transaction after the *next* beat; that next beat carries `mem_last`. The initiator raises `mem_finishes_op` on its penultimate word. A single-word write ignores `mem_finishes_op`.
- Burst address wrap: increments modulo depth; no line-alignment requirement.
- Gap between transactions: after the last beat the responder sits in IDLE for at least one cycle, so consecutive transactions are separated by ≥ 1 idle cycle. The arbiter drops `mem_enable` in that cycle.
- Abort: `mem_enable` = 0 sampled in WAIT, READ or WRITE returns to IDLE and clears outputs on that edge. A write beat whose data is sampled on that edge is not committed.
- `mem_rw`, `mem_addr` and `mem_op_size` are ignored after acceptance.
- Read throughput: one beat per cycle after the latency. Write throughput: one word per cycle; the write path has no wait states.

Decomposition:
- defines.v holds `DATA_BUS`, `MEM_READ` / `MEM_WRITE`, and state encodings `RSP_IDLE`, `RSP_WAIT`, `RSP_READ`, `RSP_WRITE`.
- Natural sub-module: `ram_word_array`, a single-port array with asynchronous read and synchronous write, parameterised by ADDR_WIDTH and INIT_FILE. The FSM, counters and output registers stay in `burst_ram_responder`.

Test Plan:
1. Burst read: preload array[0x10..0x17] = 0xA0..0xA7; enable, `mem_addr` = 0x40, read, `mem_op_size` = 0 → first valid 2 cycles after accept, then 8 consecutive beats 0xA0..0xA7, `mem_last` only on 0xA7; the next cycle is idle.
2. Burst write: `mem_addr` = 0x80, write, data 0x11*(k+1) on each `mem_req_data` → `mem_req_data` high 8 cycles starting 1 cycle after accept; `mem_last` on the 8th; array[0x20..0x27] = 0x11..0x88.
3. Single write then read: write 0xDEADBEEF to 0x1FFC with `mem_op_size` = 1 → one beat with `mem_last`; the read-back returns exactly one beat of 0xDEADBEEF with `mem_last`.
4. Wrap and early finish:
   - Burst read at the last word (0x3FFC with ADDR_WIDTH = 12) returns words 0xFFF, 0x000 … 0x006.
   - Burst write with `mem_finishes_op` on beat 2 ends after beat 3 with `mem_last`; only 4 words are written.
5. Abort and reset: drop `mem_enable` after 3 read beats → outputs 0 next cycle, FSM in IDLE. Assert `rst_n` = 0 mid-write → outputs 0 immediately; previously written words persist.
6. Back-to-back through the arbiter: inst and data requests pending together → two complete transactions with ≥ 1 idle cycle between them and no beat lost or duplicated.
